link_peer: RTL and testbench
============================

// Module: link_peer
// PURPOSE
// - External Game Boy link-cable partner for the serial port. It sits outside the dmg top, on the opposite end of the wire.
//   - It drives the DMG SIN pin and receives the DMG SOUT pin.
//   - It either follows the DMG-generated SCK (slave) or generates SCK itself (master).
// - Shifts 8-bit frames MSB first; bit out on SCK falling edge, bit in on SCK rising edge.
// - Gives the bench a byte-level tx/rx interface for serial-port tests.
// PARAMETERS
// - HALF_PERIOD  256  clk cycles per SCK half-period in master mode (256 @4.194304 MHz = 8192 Hz); >=2
// PORTS
// - clk        in   1  system clock (oversamples SCK)
// - nreset     in   1  reset, asynchronous, active-low
// - master     in   1  1 = peer generates SCK, 0 = peer follows sck_in; sampled only in IDLE
// - start      in   1  1-cycle pulse; begins a master-mode byte
// - tx_load    in   1  1-cycle pulse; writes tx_data into tx_buf
// - tx_data    in   8  next byte to transmit
// - sck_in     in   1  SCK from DMG (async)
// - sout       in   1  DMG SOUT (async)
// - sin_out    out  1  to DMG SIN
// - sck_out    out  1  peer-driven SCK level
// - sck_oe     out  1  1 while peer drives SCK
// - rx_data    out  8  last received byte
// - rx_valid   out  1  1-cycle pulse, byte complete
// - busy       out  1  frame in progress
// BEHAVIOUR
// - Reset: sin_out=1, sck_out=1, sck_oe=0, rx_data=00, rx_valid=0, busy=0, tx_buf=FF, tx_shift=FF,
//   bit_cnt=0, state IDLE, sync flops=1.
// - sck_in and sout each pass through 2-FF synchronisers (sck_s, sout_s).
//   - Edge = sck_s vs its previous value.
//   - Pin change -> action registered on the 3rd clk edge.
// - Fall action: sin_out<=tx_shift[7]; tx_shift<={tx_shift[6:0],1}.
//   - In IDLE, tx_buf is used in place of tx_shift, i.e. tx_buf is copied at frame start.
// - Rise action: rx_shift<={rx_shift[6:0],sout_s}; bit_cnt++.
// - FSM:
//   - IDLE: master=0 & falling sck_s -> S_ACT (fall action, busy=1).
//   - IDLE: master=1 & start -> M_LOW (sck_out=0, sck_oe=1, fall action, busy=1).
//   - S_ACT:
//     - Each falling edge -> fall action; each rising edge -> rise action.
//     - On the 8th rise: rx_data<=completed byte, rx_valid=1, busy=0, bit_cnt=0 -> IDLE (same cycle).
//   - M_LOW: after HALF_PERIOD cycles -> M_HIGH, sck_out=1, rise action (samples sout_s).
//   - M_HIGH: after HALF_PERIOD cycles:
//     - bit_cnt<8 -> M_LOW with fall action.
//     - bit_cnt=8 -> IDLE: sck_oe=0, rx_valid=1, rx_data updated, busy=0, bit_cnt=0.
//   - Master frame length = 16*HALF_PERIOD cycles from start to busy falling.
// - sin_out holds its last bit after a frame until the next fall action.
// - Boundary conditions:
//   - tx_load while busy: updates tx_buf only; takes effect on the next frame.
//   - tx_load in the same cycle as frame start: the new data is NOT used for that frame.
//   - start while busy or while master=0: ignored.
//   - sck_in edges: ignored in M_LOW/M_HIGH, and in IDLE when master=1.
//   - master change while busy: ignored until IDLE.
//   - Rising sck_s in IDLE: ignored (no partial frame).
//   - nreset mid-frame: immediate return to reset values, no rx_valid, partial rx discarded.
//   - rx_data is overwritten every frame; there is no overrun flag.
// TESTING
// 1. Hold nreset low, toggle all inputs -> every output at its reset value. Release -> nothing changes without stimulus.
// 2. Slave: tx_load A5, 8 sck_in pulses of period 64 clk, sout=3C MSB first:
//    - sin_out = 1,0,1,0,0,1,0,1 at successive falls (3 clk after each fall).
//    - rx_data=3C with a single rx_valid 3 clk after the 8th rise.
// 3. Master, HALF_PERIOD=4: tx_load 81, sout looped from sin_out, start:
//    - 8 sck_out low pulses of 4 clk, sck_oe=1 for 64 clk.
//    - busy falls with rx_valid; rx_data=81.
// 4. Slave: tx_load 0F after the 3rd fall of a frame sending C3 -> current frame sends C3, next frame sends 0F.
// 5. Master: nreset low during the 5th bit -> sck_oe=0 and sck_out=1 immediately; no rx_valid; next start sends from tx_buf=FF.
// 6. Master: start pulsed again mid-frame, and master toggled mid-slave-frame -> both ignored; frame completes normally with correct rx_data.

Source files
------------

// File: rtl/link_peer.sv
// Game Boy link-cable partner: drives DMG SIN, samples DMG SOUT, and either
// follows the DMG clock (slave) or generates SCK itself (master). 8-bit frames, MSB first.
module link_peer #(
  parameter int unsigned HALF_PERIOD = 256
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       master,
  input  logic       start,
  input  logic       tx_load,
  input  logic [7:0] tx_data,
  input  logic       sck_in,
  input  logic       sout,
  output logic       sin_out,
  output logic       sck_out,
  output logic       sck_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int unsigned CW = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_S_ACT  = 2'd1;
  localparam logic [1:0] ST_M_LOW  = 2'd2;
  localparam logic [1:0] ST_M_HIGH = 2'd3;

  logic [1:0]    r_state;
  logic          r_sck_m, r_sck_s, r_sck_p;
  logic          r_sout_m, r_sout_s;
  logic [7:0]    r_tx_buf, r_tx_shift, r_rx_shift, r_rx_data;
  logic [3:0]    r_bit_cnt;
  logic [CW-1:0] r_cnt;
  logic          r_sin_out, r_sck_out, r_sck_oe, r_rx_valid, r_busy;

  logic       w_fall, w_rise, w_hp_done;
  logic [7:0] w_tx_src, w_rx_next;

  assign w_fall    = r_sck_p & ~r_sck_s;
  assign w_rise    = ~r_sck_p & r_sck_s;
  assign w_hp_done = (r_cnt == HP_LAST);
  // A frame starting from IDLE shifts straight out of tx_buf, so tx_buf is copied at frame start.
  assign w_tx_src  = (r_state == ST_IDLE) ? r_tx_buf : r_tx_shift;
  assign w_rx_next = {r_rx_shift[6:0], r_sout_s};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sck_m  <= 1'b1;
      r_sck_s  <= 1'b1;
      r_sck_p  <= 1'b1;
      r_sout_m <= 1'b1;
      r_sout_s <= 1'b1;
    end else begin
      r_sck_m  <= sck_in;
      r_sck_s  <= r_sck_m;
      r_sck_p  <= r_sck_s;
      r_sout_m <= sout;
      r_sout_s <= r_sout_m;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_tx_buf   <= '1;
      r_tx_shift <= '1;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_bit_cnt  <= '0;
      r_cnt      <= '0;
      r_sin_out  <= 1'b1;
      r_sck_out  <= 1'b1;
      r_sck_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (tx_load) r_tx_buf <= tx_data;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (master) begin
            if (start) begin
              r_state    <= ST_M_LOW;
              r_sck_out  <= 1'b0;
              r_sck_oe   <= 1'b1;
              r_busy     <= 1'b1;
              r_sin_out  <= w_tx_src[7];
              r_tx_shift <= {w_tx_src[6:0], 1'b1};
            end
          end else if (w_fall) begin
            r_state    <= ST_S_ACT;
            r_busy     <= 1'b1;
            r_sin_out  <= w_tx_src[7];
            r_tx_shift <= {w_tx_src[6:0], 1'b1};
          end
        end
        ST_S_ACT: begin
          if (w_fall) begin
            r_sin_out  <= w_tx_src[7];
            r_tx_shift <= {w_tx_src[6:0], 1'b1};
          end else if (w_rise) begin
            if (r_bit_cnt == 4'd7) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_busy     <= 1'b0;
              r_bit_cnt  <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + 4'd1;
            end
          end
        end
        ST_M_LOW: begin
          if (w_hp_done) begin
            r_cnt      <= '0;
            r_state    <= ST_M_HIGH;
            r_sck_out  <= 1'b1;
            r_rx_shift <= w_rx_next;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_M_HIGH: begin
          if (w_hp_done) begin
            r_cnt <= '0;
            if (r_bit_cnt == 4'd8) begin
              r_state    <= ST_IDLE;
              r_sck_oe   <= 1'b0;
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
              r_busy     <= 1'b0;
              r_bit_cnt  <= '0;
            end else begin
              r_state    <= ST_M_LOW;
              r_sck_out  <= 1'b0;
              r_sin_out  <= w_tx_src[7];
              r_tx_shift <= {w_tx_src[6:0], 1'b1};
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sin_out  = r_sin_out;
  assign sck_out  = r_sck_out;
  assign sck_oe   = r_sck_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_link_peer.sv
// Directed bench for link_peer: reset values, slave frames, master frames with
// SOUT looped to SIN, tx_buf timing, mid-frame reset and ignored start/master changes.
module tb_link_peer;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       master = 1'b0;
  logic       start = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = '0;
  logic       sck_in = 1'b1;
  logic       sout_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       w_sout;
  logic       sin_out, sck_out, sck_oe, rx_valid, busy;
  logic [7:0] rx_data;

  int total = 0;
  int bad = 0;
  int rxv_cnt = 0;
  int oe_cyc = 0;
  int low_cyc = 0;
  int sck_falls = 0;
  logic sck_prev = 1'b1;

  always #5 clk = ~clk;

  assign w_sout = loop_en ? sin_out : sout_drv;

  link_peer #(.HALF_PERIOD(4)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .master   (master),
    .start    (start),
    .tx_load  (tx_load),
    .tx_data  (tx_data),
    .sck_in   (sck_in),
    .sout     (w_sout),
    .sin_out  (sin_out),
    .sck_out  (sck_out),
    .sck_oe   (sck_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  // Counts the level held during each completed clock cycle.
  always @(posedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (sck_oe) oe_cyc++;
    if (sck_oe && !sck_out) low_cyc++;
    if (sck_prev && !sck_out) sck_falls++;
    sck_prev = sck_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, " sin_out"}, 32'(sin_out), 1);
    chk({tag, " sck_out"}, 32'(sck_out), 1);
    chk({tag, " sck_oe"}, 32'(sck_oe), 0);
    chk({tag, " rx_data"}, 32'(rx_data), 0);
    chk({tag, " rx_valid"}, 32'(rx_valid), 0);
    chk({tag, " busy"}, 32'(busy), 0);
  endtask

  // Slave frame, SCK period 64 clk; optionally reloads tx_buf or pokes master/start mid-frame.
  task automatic slave_frame(input logic [7:0] sb, input logic [7:0] exp_tx,
                             input int load_at, input logic [7:0] load_val, input int poke_at);
    int v0;
    v0 = rxv_cnt;
    for (int i = 0; i < 8; i++) begin
      sck_in = 1'b0;
      sout_drv = sb[7-i];
      tick(3);
      chk($sformatf("slave sin bit%0d", i), 32'(sin_out), 32'(exp_tx[7-i]));
      if (i == 0) chk("slave busy", 32'(busy), 1);
      if (i == poke_at) begin
        master = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(28);
      end else if (i == load_at) begin
        load(load_val);
        tick(28);
      end else begin
        tick(29);
      end
      sck_in = 1'b1;
      if (i == 7) begin
        tick(2);
        chk("slave rx_valid early", 32'(rx_valid), 0);
        tick(1);
        chk("slave rx_valid", 32'(rx_valid), 1);
        chk("slave rx_data", 32'(rx_data), 32'(sb));
        chk("slave busy end", 32'(busy), 0);
        tick(29);
      end else begin
        tick(32);
      end
    end
    chk("slave rx_valid pulses", 32'(rxv_cnt - v0), 1);
    master = 1'b0;
  endtask

  // Master frame with HALF_PERIOD=4; optionally re-pulses start mid-frame.
  task automatic master_frame(input logic [7:0] exp_rx, input int restart_at);
    int n, v0;
    v0 = rxv_cnt;
    oe_cyc = 0;
    low_cyc = 0;
    sck_falls = 0;
    master = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 1;
    while (busy && n < 200) begin
      if (n == restart_at) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end else begin
        tick(1);
      end
      n++;
    end
    chk("master frame cycles", 32'(n - 1), 64);
    chk("master rx_valid", 32'(rx_valid), 1);
    chk("master rx_data", 32'(rx_data), 32'(exp_rx));
    chk("master sck_oe end", 32'(sck_oe), 0);
    tick(2);
    chk("master oe cycles", 32'(oe_cyc), 64);
    chk("master sck low cycles", 32'(low_cyc), 32);
    chk("master sck falls", 32'(sck_falls), 8);
    chk("master rx_valid pulses", 32'(rxv_cnt - v0), 1);
    master = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset holds outputs regardless of input activity
    for (int i = 0; i < 6; i++) begin
      master = i[0];
      start = i[1];
      tx_load = i[2];
      tx_data = 8'(i * 37);
      sck_in = ~sck_in;
      sout_drv = ~sout_drv;
      tick(1);
      idle_outputs("in reset");
    end
    master = 1'b0;
    start = 1'b0;
    tx_load = 1'b0;
    sck_in = 1'b1;
    sout_drv = 1'b1;
    tick(1);
    nreset = 1'b1;
    tick(10);
    idle_outputs("after release");

    // 2: slave A5 out, 3C in
    load(8'hA5);
    tick(4);
    slave_frame(8'h3C, 8'hA5, -1, 8'h00, -1);

    // 4: reload during a frame takes effect on the next one
    load(8'hC3);
    tick(4);
    slave_frame(8'h5A, 8'hC3, 2, 8'h0F, -1);
    slave_frame(8'h99, 8'h0F, -1, 8'h00, -1);

    // 3: master with SOUT looped back from SIN
    loop_en = 1'b1;
    load(8'h81);
    tick(2);
    master_frame(8'h81, -1);
    chk("sin_out holds last bit", 32'(sin_out), 1);

    // Falling sck_in while master=1 and rising sck_in in IDLE are both ignored
    master = 1'b1;
    sck_in = 1'b0;
    tick(6);
    chk("idle master sck fall ignored", 32'(busy), 0);
    master = 1'b0;
    tick(2);
    sck_in = 1'b1;
    tick(6);
    chk("idle sck rise ignored", 32'(busy), 0);
    chk("idle sck_oe", 32'(sck_oe), 0);

    // 5: reset during the 5th bit of a master frame
    begin
      int v0;
      master = 1'b1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(33);
      v0 = rxv_cnt;
      chk("mid busy", 32'(busy), 1);
      chk("mid sck_oe", 32'(sck_oe), 1);
      chk("mid sck_out low", 32'(sck_out), 0);
      nreset = 1'b0;
      #1;
      chk("async rst sck_oe", 32'(sck_oe), 0);
      chk("async rst sck_out", 32'(sck_out), 1);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst sin_out", 32'(sin_out), 1);
      tick(2);
      master = 1'b0;
      nreset = 1'b1;
      tick(4);
      chk("no rx_valid after rst", 32'(rxv_cnt - v0), 0);
      chk("rx_data after rst", 32'(rx_data), 0);
      master_frame(8'hFF, -1);
    end

    // 6: start re-pulsed mid master frame; master toggled mid slave frame
    load(8'h6B);
    tick(2);
    master_frame(8'h6B, 20);
    loop_en = 1'b0;
    load(8'h2D);
    tick(4);
    slave_frame(8'hE7, 8'h2D, -1, 8'h00, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
